// File: rtl/vram_port_if.sv
// vram_port_if: single-word CPU request/acknowledge bus into the VRAM port-A controller.
interface vram_port_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/vram_port_ctrl.sv
// vram_port_ctrl: port-A sequencer/arbiter sharing the VRAM write/read port between CPU accesses
// and the framebuffer fill engine. The fill engine and arbitration exist only with VRAM_FILL_EN defined.
module vram_port_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int TEXT_WORDS = 4800,
  parameter int GFX_WORDS  = 38400,
  parameter int CPU_BURST  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  vram_port_if.slave        cpu,
  input  logic              fill_start_i,
  input  logic              fill_mode_i,
  input  logic [DATA_W-1:0] fill_value_i,
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              bram_we_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_din_o,
  input  logic [DATA_W-1:0] bram_dout_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CPU_WR  = 3'd1;
  localparam logic [2:0] S_CPU_RD1 = 3'd2;
  localparam logic [2:0] S_CPU_RD2 = 3'd3;
  localparam logic [2:0] S_CPU_ACK = 3'd4;
  localparam logic [2:0] S_FILL_WR = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;

  logic              grant_cpu;
  logic              grant_fill;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

`ifdef VRAM_FILL_EN
  localparam int                STREAK_W  = $clog2(CPU_BURST + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(CPU_BURST);
  localparam logic [ADDR_W-1:0] TEXT_LAST = ADDR_W'(TEXT_WORDS - 1);
  localparam logic [ADDR_W-1:0] GFX_LAST  = ADDR_W'(GFX_WORDS - 1);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                fill_pend_q, fill_pend_d;
  logic                fill_done_q, fill_done_d;
  logic [ADDR_W-1:0]   fill_ptr_q, fill_ptr_d;
  logic [ADDR_W-1:0]   fill_last_q, fill_last_d;
  logic [DATA_W-1:0]   fill_val_q, fill_val_d;
  logic                fill_accept;

  // The pending flag doubles as fill_busy: both rise the cycle after an accepted start.
  assign fill_accept = fill_start_i && !fill_pend_q;
  assign grant_cpu   = cpu.cpu_req && (!fill_pend_q || (streak_q < BURST_MAX));
  assign grant_fill  = fill_pend_q && (!cpu.cpu_req || (streak_q == BURST_MAX));
  assign fill_addr   = fill_ptr_q;
  assign fill_data   = fill_val_q;

  always_comb begin
    streak_d    = streak_q;
    fill_pend_d = fill_pend_q;
    fill_done_d = 1'b0;
    fill_ptr_d  = fill_ptr_q;
    fill_last_d = fill_last_q;
    fill_val_d  = fill_val_q;

    if (fill_accept) begin
      fill_val_d  = fill_value_i;
      fill_last_d = fill_mode_i ? GFX_LAST : TEXT_LAST;
      fill_ptr_d  = '0;
      fill_pend_d = 1'b1;
    end

    // The pointer parks on the last word so it never wraps past the framebuffer.
    if (state_q == S_FILL_WR) begin
      if (fill_ptr_q == fill_last_q) begin
        fill_pend_d = 1'b0;
        fill_done_d = 1'b1;
      end else begin
        fill_ptr_d = fill_ptr_q + 1'b1;
      end
    end

    if (!fill_pend_q) begin
      streak_d = '0;
    end else if ((state_q == S_IDLE) && grant_fill) begin
      streak_d = '0;
    end else if ((state_q == S_IDLE) && grant_cpu && (streak_q < BURST_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      streak_q    <= '0;
      fill_pend_q <= 1'b0;
      fill_done_q <= 1'b0;
      fill_ptr_q  <= '0;
    end else begin
      streak_q    <= streak_d;
      fill_pend_q <= fill_pend_d;
      fill_done_q <= fill_done_d;
      fill_ptr_q  <= fill_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_last_q <= fill_last_d;
    fill_val_q  <= fill_val_d;
  end

  assign fill_busy_o = fill_pend_q;
  assign fill_done_o = fill_done_q;
`else
  logic unused_fill;

  assign unused_fill = ^{fill_start_i, fill_mode_i, fill_value_i};
  assign grant_cpu   = cpu.cpu_req;
  assign grant_fill  = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
  assign fill_busy_o = 1'b0;
  assign fill_done_o = 1'b0;
`endif

  // Port-A controls are registered at the IDLE decision so they are live during the access state.
  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;

    case (state_q)
      S_IDLE: begin
        if (grant_cpu) begin
          bram_addr_d = cpu.cpu_addr;
          if (cpu.cpu_we) begin
            state_d    = S_CPU_WR;
            bram_we_d  = 1'b1;
            bram_din_d = cpu.cpu_wdata;
          end else begin
            state_d = S_CPU_RD1;
          end
        end else if (grant_fill) begin
          state_d     = S_FILL_WR;
          bram_we_d   = 1'b1;
          bram_addr_d = fill_addr;
          bram_din_d  = fill_data;
        end
      end
      S_CPU_WR: begin
        state_d   = S_CPU_ACK;
        cpu_ack_d = 1'b1;
      end
      S_CPU_RD1: begin
        state_d = S_CPU_RD2;
      end
      S_CPU_RD2: begin
        state_d     = S_CPU_ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = bram_dout_i;
      end
      S_CPU_ACK: begin
        state_d = S_IDLE;
      end
      S_FILL_WR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign cpu.cpu_ack   = cpu_ack_q;
  assign cpu.cpu_rdata = cpu_rdata_q;
  assign bram_we_o     = bram_we_q;
  assign bram_addr_o   = bram_addr_q;
  assign bram_din_o    = bram_din_q;

endmodule

// File: tb/tb_vram_port_ctrl.sv
// Bench for vram_port_ctrl: table of CPU accesses with exact latencies, then fill/reset sequences.
module tb_vram_port_ctrl;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int TEXT_WORDS = 4800;
  localparam int GFX_WORDS  = 96;
  localparam int CPU_BURST  = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        fill_start = 1'b0;
  logic        fill_mode = 1'b0;
  logic [7:0]  fill_value = 8'h00;
  logic        fill_busy, fill_done, bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_din;
  logic [7:0]  bram_dout = 8'h00;

  vram_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu_if ();

  vram_port_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEXT_WORDS(TEXT_WORDS),
    .GFX_WORDS(GFX_WORDS), .CPU_BURST(CPU_BURST)
  ) dut (
    .clk(clk), .resetn(resetn), .cpu(cpu_if),
    .fill_start_i(fill_start), .fill_mode_i(fill_mode), .fill_value_i(fill_value),
    .fill_busy_o(fill_busy), .fill_done_o(fill_done),
    .bram_we_o(bram_we), .bram_addr_o(bram_addr), .bram_din_o(bram_din),
    .bram_dout_i(bram_dout)
  );

  always #5 clk = ~clk;

  // Registered-output BRAM model fed from values captured mid-cycle.
  logic [7:0]  mem [0:65535];
  logic        s_we = 1'b0;
  logic [15:0] s_addr = 16'h0000;
  logic [7:0]  s_din = 8'h00;

  always @(posedge clk) begin
    bram_dout <= mem[s_addr];
    if (s_we) mem[s_addr] <= s_din;
  end

  logic        mon_clr = 1'b1;
  logic        mon_fill = 1'b0;
  logic        mon_pat = 1'b0;
  logic [7:0]  mon_val = 8'h00;
  logic [15:0] exp_addr = 16'h0000;
  int cyc = 0, wr_cnt = 0, seq_bad = 0, val_bad = 0, pat_bad = 0, done_cnt = 0;
  int acks_since = 0, first_we_cyc = 0, last_we_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    s_we   <= bram_we;
    s_addr <= bram_addr;
    s_din  <= bram_din;
    cyc    <= cyc + 1;
    if (mon_clr) begin
      wr_cnt <= 0; seq_bad <= 0; val_bad <= 0; pat_bad <= 0; done_cnt <= 0;
      acks_since <= 0; exp_addr <= 16'h0000;
    end else begin
      if (cpu_if.cpu_ack) acks_since <= acks_since + 1;
      if (bram_we) begin
        wr_cnt <= wr_cnt + 1;
        if (mon_fill) begin
          if (wr_cnt == 0) first_we_cyc <= cyc;
          last_we_cyc <= cyc;
          if (bram_addr != exp_addr) seq_bad <= seq_bad + 1;
          if (bram_din != mon_val) val_bad <= val_bad + 1;
          if (mon_pat && (acks_since != CPU_BURST)) pat_bad <= pat_bad + 1;
          acks_since <= 0;
          exp_addr <= exp_addr + 16'h0001;
        end
      end
      if (fill_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, {28'd0, cpu_if.cpu_ack, fill_busy, fill_done, bram_we}, 32'd0);
    chk({nm, "_addr"}, {16'd0, bram_addr}, 32'd0);
    chk({nm, "_din"}, {24'd0, bram_din}, 32'd0);
    chk({nm, "_rdata"}, {24'd0, cpu_if.cpu_rdata}, 32'd0);
  endtask

  // One CPU access from IDLE with exact-latency checks; assumes no fill is pending.
  task automatic cpu_op(input string nm, input logic we, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = we; cpu_if.cpu_addr = a; cpu_if.cpu_wdata = d;
    while (!got && lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin
        chk({nm, "_we"}, {31'd0, bram_we}, {31'd0, we});
        chk({nm, "_addr"}, {16'd0, bram_addr}, {16'd0, a});
        if (we) chk({nm, "_din"}, {24'd0, bram_din}, {24'd0, d});
      end
      if (cpu_if.cpu_ack) got = 1'b1;
    end
    cpu_if.cpu_req = 1'b0;
    chk({nm, "_lat"}, lat, we ? 32'd2 : 32'd3);
    if (!we) begin
      chk({nm, "_rdata"}, {24'd0, cpu_if.cpu_rdata}, {24'd0, exp});
      last_rd = exp;
    end
    tick();
    chk({nm, "_ackpulse"}, {31'd0, cpu_if.cpu_ack}, 32'd0);
    chk({nm, "_hold"}, {24'd0, cpu_if.cpu_rdata}, {24'd0, last_rd});
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required summary before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, j, nrd, n2;
    vecs[0]  = '{we: 1'b1, addr: 16'h0010, wdata: 8'hA5, exp: 8'h00};
    vecs[1]  = '{we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp: 8'hA5};
    vecs[2]  = '{we: 1'b1, addr: 16'hFFFF, wdata: 8'h3C, exp: 8'h00};
    vecs[3]  = '{we: 1'b1, addr: 16'h0000, wdata: 8'hC3, exp: 8'h00};
    vecs[4]  = '{we: 1'b0, addr: 16'hFFFF, wdata: 8'h00, exp: 8'h3C};
    vecs[5]  = '{we: 1'b0, addr: 16'h0000, wdata: 8'h00, exp: 8'hC3};
    vecs[6]  = '{we: 1'b1, addr: 16'h0010, wdata: 8'h5A, exp: 8'h00};
    vecs[7]  = '{we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp: 8'h5A};
    vecs[8]  = '{we: 1'b1, addr: 16'h0011, wdata: 8'h77, exp: 8'h00};
    vecs[9]  = '{we: 1'b0, addr: 16'h0011, wdata: 8'h00, exp: 8'h77};
    vecs[10] = '{we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp: 8'h5A};
    vecs[11] = '{we: 1'b1, addr: 16'hFFFF, wdata: 8'hE7, exp: 8'h00};

    cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 16'h0000; cpu_if.cpu_wdata = 8'h00;
    tick();
    tick();
    chk_zero("reset");
    resetn = 1'b1;
    mon_clr = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      cpu_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_zero("reset_after_cpu");
    last_rd = 8'h00;
    tick();

`ifdef VRAM_FILL_EN
    for (int i = 0; i < 8; i++)
      cpu_op($sformatf("pool%0d", i), 1'b1, 16'h8000 + 16'(i), 8'h30 + 8'(i), 8'h00);
    cpu_op("pre4800", 1'b1, 16'd4800, 8'h99, 8'h00);
    cpu_op("pre4799", 1'b1, 16'd4799, 8'h66, 8'h00);

    // Text fill with no CPU traffic.
    clear_mon();
    mon_fill = 1'b1; mon_val = 8'h20; mon_pat = 1'b0;
    fill_mode = 1'b0; fill_value = 8'h20; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    chk("txt_busy", {31'd0, fill_busy}, 32'd1);
    n = 0;
    while (done_cnt == 0 && n < 12000) begin tick(); n++; end
    chk("txt_busy_fall", {31'd0, fill_busy}, 32'd0);
    chk("txt_done_pulse", {31'd0, fill_done}, 32'd0);
    repeat (10) tick();
    chk("txt_writes", wr_cnt, 32'd4800);
    chk("txt_seq", seq_bad, 32'd0);
    chk("txt_val", val_bad, 32'd0);
    chk("txt_done_cnt", done_cnt, 32'd1);
    chk("txt_done_lag", done_cyc - last_we_cyc, 32'd1);
    chk("txt_span", last_we_cyc - first_we_cyc, 32'd9598);
    mon_fill = 1'b0;
    cpu_op("txt_rd0", 1'b0, 16'd0, 8'h00, 8'h20);
    cpu_op("txt_rd4799", 1'b0, 16'd4799, 8'h00, 8'h20);
    cpu_op("txt_rd4800", 1'b0, 16'd4800, 8'h00, 8'h99);

    // Graphics fill under continuous CPU reads, with an ignored restart attempt.
    clear_mon();
    mon_fill = 1'b1; mon_val = 8'h00; mon_pat = 1'b1;
    fill_mode = 1'b1; fill_value = 8'h00; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    j = 0; nrd = 0; n = 0;
    cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 16'h8000;
    while (done_cnt == 0 && n < 4000) begin
      tick();
      n++;
      fill_start = (n == 200);
      fill_value = (n == 200) ? 8'hFF : 8'h00;
      fill_mode  = (n == 200) ? 1'b0 : 1'b1;
      if (cpu_if.cpu_ack) begin
        chk($sformatf("gfx_rd%0d", nrd), {24'd0, cpu_if.cpu_rdata}, {24'd0, 8'h30 + 8'(j)});
        j = (j + 1) % 8;
        cpu_if.cpu_addr = 16'h8000 + 16'(j);
        nrd++;
      end
    end
    fill_start = 1'b0;
    n2 = 0;
    while (!cpu_if.cpu_ack && n2 < 12) begin tick(); n2++; end
    cpu_if.cpu_req = 1'b0;
    repeat (8) tick();
    chk("gfx_writes", wr_cnt, GFX_WORDS);
    chk("gfx_seq", seq_bad, 32'd0);
    chk("gfx_val", val_bad, 32'd0);
    chk("gfx_pattern", pat_bad, 32'd0);
    chk("gfx_done_cnt", done_cnt, 32'd1);
    chk("gfx_nreads", {31'd0, nrd >= GFX_WORDS * CPU_BURST}, 32'd1);
    chk("gfx_busy_end", {31'd0, fill_busy}, 32'd0);

    // Reset in the middle of a fill aborts it.
    clear_mon();
    mon_fill = 1'b1; mon_val = 8'h11; mon_pat = 1'b0;
    fill_mode = 1'b0; fill_value = 8'h11; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    n = 0;
    while (wr_cnt < 100 && n < 1000) begin tick(); n++; end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk_zero("rstfill");
    repeat (40) tick();
    chk("rstfill_writes", wr_cnt, 32'd100);
    chk("rstfill_seq", seq_bad, 32'd0);
    chk("rstfill_nodone", done_cnt, 32'd0);
    chk("rstfill_busy", {31'd0, fill_busy}, 32'd0);

    clear_mon();
    mon_fill = 1'b1; mon_val = 8'h44;
    fill_mode = 1'b1; fill_value = 8'h44; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin tick(); n++; end
    repeat (4) tick();
    chk("refill_writes", wr_cnt, GFX_WORDS);
    chk("refill_seq", seq_bad, 32'd0);
    chk("refill_val", val_bad, 32'd0);
    chk("refill_done_cnt", done_cnt, 32'd1);
    mon_fill = 1'b0;
`else
    clear_mon();
    fill_mode = 1'b1; fill_value = 8'h77; fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    chk("nofill_busy", {31'd0, fill_busy}, 32'd0);
    repeat (30) tick();
    chk("nofill_writes", wr_cnt, 32'd0);
    chk("nofill_done", done_cnt, 32'd0);
    fill_start = 1'b1;
    cpu_op("nofill_wr", 1'b1, 16'h0200, 8'h4B, 8'h00);
    cpu_op("nofill_rd", 1'b0, 16'h0200, 8'h00, 8'h4B);
    fill_start = 1'b0;
    chk("nofill_writes_cpu", wr_cnt, 32'd1);
    chk("nofill_busy_end", {31'd0, fill_busy}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
